sender_scheduler: RTL and testbench
===================================

# sender_scheduler

Round-robin scheduler that shares the single serial `sender` among N byte-producing requesters. It accepts one byte at a time over a valid/ready handshake. It loads the byte into the sender's `tx_data`, pulses `tx_en` for one `clk` cycle, then tracks the sender's `tx_status` through busy and back to idle before granting again. It sits directly in front of `sender` in the serial transceiver, on the `clk` domain.

## Interface
- `N`, default 4: number of requesters, range 2..8.
- `ACK_TIMEOUT`, default 64: `clk` cycles to wait for the sender to go busy after `tx_en` before re-issuing.
- `clk`  in  1  system clock; `sender`'s `clk` is the same net.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  N  requester i holds a byte.
- `req_data`  in  8*N  byte of requester i in bits [8i+7:8i].
- `req_ready`  out  N  one-hot; a byte is accepted on a rising edge where `req_valid[i] & req_ready[i]`.
- `tx_data`  out  8  byte to the sender, registered.
- `tx_en`  out  1  one-cycle load strobe to the sender, registered.
- `tx_status`  in  1  from the sender: 1 = idle, 0 = transmitting. Comes from the `send_clk` domain.
- `grant_id`  out  max(1,$clog2(N))  index of the requester being served.
- `busy`  out  1  a byte is in flight (any state other than IDLE).
- `timeout_err`  out  1  one-cycle pulse on each ACK_TIMEOUT expiry.

## Operation
- `tx_status` passes through a 2-flop synchronizer, producing `st_s`. `st_s` resets to 0, so nothing is granted until the sender reads idle.
- Requester rules: `req_valid` must stay high and `req_data` stable until accepted. Dropping `req_valid` early is illegal, and the bench asserts on it.
- Arbitration is round-robin. Search starts at pointer `rr`, which resets to 0, and takes the first i with `req_valid[i]`, wrapping modulo N.
- `req_ready` is combinational: it is the one-hot grant when state==IDLE and `st_s`==1, otherwise 0.
- FSM states:
  - **IDLE**: on accept, `tx_data` ← selected byte, `grant_id` ← i, `tx_en` ← 1, counter ← 0, go to WAIT_BUSY.
  - **WAIT_BUSY**:
    - `tx_en` ← 0 after its one cycle.
    - If `st_s`==0, go to WAIT_DONE.
    - Otherwise, when counter == ACK_TIMEOUT−1: `timeout_err` pulse, `tx_en` ← 1 again with the same `tx_data`, counter ← 0, stay in WAIT_BUSY. Retries are unlimited.
    - Otherwise counter+1.
  - **WAIT_DONE**: when `st_s`==1, `rr` ← (`grant_id`+1) mod N and go to IDLE.
- The counter width is $clog2(ACK_TIMEOUT+1).
- `tx_data` holds its value after the transfer until the next accept.

## Timing
- Reset values: `tx_en`=0, `tx_data`=0, `grant_id`=0, `busy`=0, `timeout_err`=0, `rr`=0, state IDLE, `req_ready`=0.
- Accept at edge k:
  - `tx_en`=1 and the new `tx_data` are visible in cycle k..k+1 only.
  - `busy`=1 from k+1.
- Sender busy/idle edges appear in `st_s` two `clk` edges late.
- Return to IDLE occurs on the edge where `st_s` reads 1. The next `req_ready` can be high in the cycle after that edge. There is no back-to-back grant in the WAIT_DONE→IDLE cycle.
- Simultaneous valids are resolved purely by `rr`. A requester that is newly valid during the search is included only if it is at or after the pointer in wrap order.
- Reset mid-transfer:
  - All outputs return to reset values immediately and the in-flight byte is lost.
  - Its requester has already seen `req_ready`, so it does not re-send.
- If `st_s`==0 while in IDLE (sender still busy), nothing is granted.
- `timeout_err` never coincides with the first `tx_en` of a grant.

## Structure
- Package `sender_pkg` holds:
  - the state enum (IDLE, WAIT_BUSY, WAIT_DONE);
  - `DATA_W`=8;
  - a function computing `grant_id` width from N.
- Sub-module `rr_arbiter`: combinational, with inputs `req` N bits and `ptr`, and outputs one-hot `gnt` and encoded `idx`.
- The synchronizer, FSM, timeout counter and data register stay in `sender_scheduler`.

## Test plan
- Single request: `req_valid`=4'b0001, data 8'hC5 → `req_ready[0]` for one cycle, then `tx_en` one cycle with `tx_data`=8'hC5. `sender` shifts out C5, and `busy` drops after `tx_status` returns to 1.
- Contention: all four valid with 8'h10..8'h13 → service order 0,1,2,3. The sender's `dout` frames carry 10,11,12,13, and the next round starts again at 0.
- Fairness across a wrap: `rr`=3, valids {0,3} → 3 served, then 0.
- Stuck sender, with `tx_status` tied to 1 and ACK_TIMEOUT=8 → `timeout_err` every 8 cycles. Each pulse is accompanied by a repeated `tx_en` with unchanged `tx_data`, and `req_ready` stays 0.
- Reset mid-transfer: `rst_n` low during WAIT_DONE → `tx_en`=0, `busy`=0, `rr`=0 immediately. After release and `st_s`=1, a pending request is granted normally.
- Sender busy at release of reset, with `tx_status`=0 → no `req_ready` until two edges after `tx_status` rises.

Source files
------------

// File: rtl/sender_pkg.sv
// -----------------------------------------------------------------------------
// sender_pkg
// Shared types and constants for the sender scheduler.
//   state_e  : scheduler FSM states (IDLE, WAIT_BUSY, WAIT_DONE)
//   DATA_W   : width of one requester byte / sender load word
//   id_width : width of a requester index for N requesters (at least 1 bit)
// -----------------------------------------------------------------------------
package sender_pkg;

   localparam int DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_BUSY = 2'd1,
      WAIT_DONE = 2'd2
   } state_e;

   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sender_scheduler_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: the first asserted request at or after ptr,
// wrapping modulo N.
//   req [N-1:0]  : request vector
//   ptr [IW-1:0] : index where the search starts (always < N)
//   gnt [N-1:0]  : one-hot grant, all zero when no request is asserted
//   idx [IW-1:0] : encoded grant index, 0 when no request is asserted
// -----------------------------------------------------------------------------
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx
);

   int          pos;
   logic [IW-1:0] pidx;
   logic        found;

   always_comb begin
      // NOTE: every variable written here gets a default first, so no path
      // leaves one unassigned and no latch is inferred.
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      pos   = 0;
      pidx  = '0;
      for (int k = 0; k < N; k++) begin
         pos = int'(ptr) + k;
         if (pos >= N) pos = pos - N;
         pidx = IW'(pos);
         if (!found && req[pidx]) begin
            found     = 1'b1;
            gnt[pidx] = 1'b1;
            idx       = pidx;
         end
      end
   end

endmodule

// File: rtl/sender_scheduler.sv
// -----------------------------------------------------------------------------
// sender_scheduler
// Shares one serial sender among N byte requesters. A byte is accepted over a
// valid/ready handshake, loaded into tx_data with a one-cycle tx_en strobe, and
// the sender's idle/busy status is tracked back to idle before the next grant.
// If the sender never reports busy, tx_en is re-issued every ACK_TIMEOUT cycles.
//   clk, rst_n     : clock, asynchronous active-low reset
//   req_valid [N]  : requester i holds a byte
//   req_data [8N]  : byte of requester i in bits [8i+7:8i]
//   req_ready [N]  : one-hot accept strobe (combinational)
//   tx_data [8]    : byte to the sender (registered, held until next accept)
//   tx_en          : one-cycle load strobe to the sender (registered)
//   tx_status      : sender status, 1 = idle, 0 = transmitting (async)
//   grant_id       : index of the requester being served
//   busy           : a byte is in flight
//   timeout_err    : one-cycle pulse on each ACK_TIMEOUT expiry
// -----------------------------------------------------------------------------
module sender_scheduler
   import sender_pkg::*;
#(
   parameter  int N           = 4,
   parameter  int ACK_TIMEOUT = 64,
   localparam int IW          = id_width(N)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [N-1:0]        req_valid,
   input  logic [DATA_W*N-1:0] req_data,
   output logic [N-1:0]        req_ready,
   output logic [DATA_W-1:0]   tx_data,
   output logic                tx_en,
   input  logic                tx_status,
   output logic [IW-1:0]       grant_id,
   output logic                busy,
   output logic                timeout_err
);

   localparam int CW = $clog2(ACK_TIMEOUT + 1);

   state_e              state_q;
   logic [1:0]          sync_q;
   logic                st_s;
   logic [IW-1:0]       rr_q;
   logic [IW-1:0]       grant_q;
   logic [CW-1:0]       cnt_q;
   logic [DATA_W-1:0]   tx_data_q;
   logic                tx_en_q;
   logic                terr_q;

   logic [N-1:0]        arb_gnt;
   logic [IW-1:0]       arb_idx;
   logic [DATA_W-1:0]   sel_data;
   logic                can_grant;
   logic                accept;

   // tx_status is produced in the sender's send_clk domain; resetting the
   // synchronizer to 0 keeps the scheduler quiet until the sender reads idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= 2'b00;
      else        sync_q <= {sync_q[0], tx_status};
   end
   assign st_s = sync_q[1];

   rr_arbiter #(
      .N  (N),
      .IW (IW)
   ) u_arb (
      .req (req_valid),
      .ptr (rr_q),
      .gnt (arb_gnt),
      .idx (arb_idx)
   );

   // AND-OR byte select from the one-hot grant.
   always_comb begin
      sel_data = '0;
      for (int i = 0; i < N; i++) begin
         if (arb_gnt[i]) sel_data = req_data[i*DATA_W +: DATA_W];
      end
   end

   assign can_grant = (state_q == IDLE) && st_s;
   assign req_ready = can_grant ? arb_gnt : '0;
   assign accept    = can_grant && (|arb_gnt);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         rr_q      <= '0;
         grant_q   <= '0;
         cnt_q     <= '0;
         tx_data_q <= '0;
         tx_en_q   <= 1'b0;
         terr_q    <= 1'b0;
      end else begin
         // Both strobes are single-cycle unless re-armed below.
         tx_en_q <= 1'b0;
         terr_q  <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (accept) begin
                  tx_data_q <= sel_data;
                  grant_q   <= arb_idx;
                  tx_en_q   <= 1'b1;
                  cnt_q     <= '0;
                  state_q   <= WAIT_BUSY;
               end
            end
            WAIT_BUSY: begin
               if (!st_s) begin
                  state_q <= WAIT_DONE;
               end else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
                  // Sender never went busy: reload the same byte and retry.
                  terr_q  <= 1'b1;
                  tx_en_q <= 1'b1;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            WAIT_DONE: begin
               if (st_s) begin
                  rr_q    <= (grant_q == IW'(N - 1)) ? '0 : grant_q + 1'b1;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign tx_data     = tx_data_q;
   assign tx_en       = tx_en_q;
   assign grant_id    = grant_q;
   assign busy        = (state_q != IDLE);
   assign timeout_err = terr_q;

endmodule

// File: tb/tb_sender_scheduler.sv
// -----------------------------------------------------------------------------
// tb_sender_scheduler
// Scoreboard bench: each batch of simultaneous requests is turned into its
// expected service order (wrap order from the round-robin pointer) and pushed
// into a queue; an independent monitor pops and compares on every first tx_en.
// A behavioural sender answers tx_en by going busy for a random time.
// -----------------------------------------------------------------------------
module tb_sender_scheduler;

   localparam int N   = 4;
   localparam int ACK = 8;
   localparam int IW  = 2;

   typedef struct {
      int         id;
      logic [7:0] data;
   } exp_t;

   logic            clk;
   logic            rst_n;
   logic [N-1:0]    req_valid;
   logic [8*N-1:0]  req_data;
   logic [N-1:0]    req_ready;
   logic [7:0]      tx_data;
   logic            tx_en;
   logic            tx_status_w;
   logic [IW-1:0]   grant_id;
   logic            busy;
   logic            timeout_err;

   logic            snd_status;
   logic            hold_busy;
   logic            sender_stuck;
   logic            tb_done;

   int              tests;
   int              fails;
   exp_t            exp_q[$];
   int              model_rr;
   logic [7:0]      last_exp_data;
   logic [7:0]      last_tx;

   logic [N-1:0]    s_ready;
   logic            s_tx_en;
   logic            s_terr;
   logic [7:0]      s_data;

   assign tx_status_w = snd_status && !hold_busy;

   sender_scheduler #(
      .N           (N),
      .ACK_TIMEOUT (ACK)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .tx_data     (tx_data),
      .tx_en       (tx_en),
      .tx_status   (tx_status_w),
      .grant_id    (grant_id),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: all requesters in the mask are valid together and stay valid
   // until served, so they are served once each in wrap order from the pointer,
   // and the pointer ends one past the last one served.
   task automatic issue(input logic [N-1:0] mask, input logic [8*N-1:0] data);
      int last;
      last = model_rr;
      for (int k = 0; k < N; k++) begin
         int i;
         exp_t e;
         i = (model_rr + k) % N;
         if (mask[i]) begin
            e.id   = i;
            e.data = data[i*8 +: 8];
            exp_q.push_back(e);
            last_exp_data = e.data;
            last = i;
         end
      end
      model_rr  = (last + 1) % N;
      req_data  = data;
      req_valid = mask;
   endtask

   // One clock: sample outputs at the falling edge, let the rising edge
   // accept, then withdraw the requesters that were accepted.
   task automatic step();
      logic [N-1:0] acc;
      @(negedge clk);
      s_ready = req_ready;
      s_tx_en = tx_en;
      s_terr  = timeout_err;
      s_data  = tx_data;
      acc     = req_valid & req_ready;
      if (req_ready != '0) begin
         check("ready_onehot", 32'($onehot(req_ready)), 1);
         check("ready_within_valid", 32'(req_ready & ~req_valid), 0);
      end
      @(posedge clk);
      #1;
      req_valid = req_valid & ~acc;
   endtask

   task automatic drain(input string name);
      int cyc;
      cyc = 0;
      while ((req_valid != '0 || busy || exp_q.size() != 0) && cyc < 3000) begin
         step();
         cyc++;
      end
      check({name, "_drained"}, 32'(cyc < 3000), 1);
      check({name, "_tx_data_held"}, 32'(tx_data), 32'(last_exp_data));
   endtask

   // Behavioural sender: goes busy shortly after a load strobe, then idle.
   initial begin
      snd_status = 1'b1;
      forever begin
         @(negedge clk);
         if (tx_en && rst_n && !sender_stuck) begin
            repeat ($urandom_range(1, 2)) @(negedge clk);
            snd_status = 1'b0;
            repeat ($urandom_range(3, 8)) @(negedge clk);
            snd_status = 1'b1;
         end
      end
   end

   // Monitor: every first tx_en of a grant must match the scoreboard head;
   // every timeout pulse must carry a repeated tx_en with unchanged data.
   always @(negedge clk) begin
      if (rst_n && !tb_done) begin
         if (timeout_err) begin
            check("retry_tx_en", 32'(tx_en), 1);
            check("retry_tx_data", 32'(tx_data), 32'(last_tx));
         end else if (tx_en) begin
            if (exp_q.size() == 0) begin
               check("unexpected_grant_id", 32'(grant_id), 32'hFFFF);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("grant_id", 32'(grant_id), 32'(e.id));
               check("tx_data", 32'(tx_data), 32'(e.data));
               check("busy_with_tx_en", 32'(busy), 1);
            end
            last_tx = tx_data;
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      int run;
      int cnt;
      logic [7:0] d0;
      logic ok_ready;

      tests = 0; fails = 0; tb_done = 1'b0;
      rst_n = 1'b0; req_valid = '0; req_data = '0;
      hold_busy = 1'b1; sender_stuck = 1'b0;
      model_rr = 0; last_exp_data = '0; last_tx = '0;

      repeat (3) @(posedge clk);
      #1;
      check("reset_tx_en", 32'(tx_en), 0);
      check("reset_tx_data", 32'(tx_data), 0);
      check("reset_grant_id", 32'(grant_id), 0);
      check("reset_busy", 32'(busy), 0);
      check("reset_timeout_err", 32'(timeout_err), 0);
      check("reset_req_ready", 32'(req_ready), 0);

      // Sender busy when reset releases: no grant until st_s reads idle.
      issue(4'b0001, {24'h0, 8'hC5});
      @(negedge clk) rst_n = 1'b1;
      repeat (6) begin
         step();
         check("ready_while_sender_busy", 32'(s_ready), 0);
      end
      hold_busy = 1'b0;
      step();
      step();
      check("ready_one_edge_after_idle", 32'(s_ready), 0);
      step();
      check("ready_two_edges_after_idle", 32'(s_ready), 32'b0001);
      drain("single_c5");

      // Contention across all requesters.
      issue(4'b1111, {8'h13, 8'h12, 8'h11, 8'h10});
      drain("contention");

      // Wrap fairness: serve 2 alone, pointer lands on 3, then {0,3}.
      issue(4'b0100, {8'h00, 8'h5A, 8'h00, 8'h00});
      drain("set_ptr");
      issue(4'b1001, {8'hA3, 8'h00, 8'h00, 8'hA0});
      drain("wrap");

      // Stuck sender: periodic timeout with repeated strobe, no new grants.
      sender_stuck = 1'b1;
      issue(4'b0110, {8'h00, 8'h62, 8'h61, 8'h00});
      cyc = 0;
      do begin
         step();
         cyc++;
      end while (!s_tx_en && cyc < 40);
      check("stuck_first_tx_en", 32'(s_tx_en), 1);
      d0 = s_data;
      for (int p = 0; p < 3; p++) begin
         cnt = 0;
         ok_ready = 1'b1;
         do begin
            step();
            cnt++;
            if (s_ready != '0) ok_ready = 1'b0;
         end while (!s_terr && cnt < 20);
         check("timeout_period", 32'(cnt), ACK);
         check("timeout_tx_en", 32'(s_tx_en), 1);
         check("timeout_same_data", 32'(s_data), 32'(d0));
         check("stuck_no_ready", 32'(ok_ready), 1);
      end
      sender_stuck = 1'b0;
      drain("stuck");

      // Reset while waiting for the sender to finish.
      issue(4'b0100, {8'h00, 8'h77, 8'h00, 8'h00});
      cyc = 0;
      run = 0;
      while (run < 3 && cyc < 200) begin
         step();
         cyc++;
         if (busy && !tx_status_w) run++;
         else run = 0;
      end
      check("reached_wait_done", 32'(cyc < 200), 1);
      rst_n = 1'b0;
      #1;
      check("midreset_tx_en", 32'(tx_en), 0);
      check("midreset_busy", 32'(busy), 0);
      check("midreset_grant_id", 32'(grant_id), 0);
      check("midreset_tx_data", 32'(tx_data), 0);
      check("midreset_req_ready", 32'(req_ready), 0);
      model_rr = 0;
      issue(4'b1010, {8'hB3, 8'h00, 8'hB1, 8'h00});
      repeat (3) begin
         step();
         check("ready_in_reset", 32'(s_ready), 0);
      end
      @(negedge clk) rst_n = 1'b1;
      drain("after_reset");

      // Randomized batches.
      for (int b = 0; b < 30; b++) begin
         logic [N-1:0] m;
         m = N'($urandom_range(1, (1 << N) - 1));
         issue(m, {$urandom});
         drain("random");
      end

      tb_done = 1'b1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
